vpl_alu_seq_v: RTL and testbench
================================

# vpl_alu_seq_v

Parametrised, registered successor to the team's 4-bit combinational ALU: a WIDTH-bit ALU with a valid/ready handshake on input and output, registered results and status flags, and a multi-cycle shift-add multiply. It sits between the operand register file and the writeback stage of the datapath, and back-pressures upstream while a result is unconsumed or a multiply is in progress.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block accepts a request this cycle
- func_sel  in  4  operation code, sampled on accept
- operand_a  in  WIDTH  operand A, sampled on accept
- operand_b  in  WIDTH  operand B, sampled on accept
- out_valid  out  1  result and flags valid
- out_ready  in  1  downstream consumes result
- alu_result  out  WIDTH  registered result
- alu_cout  out  1  carry out / multiply high-part-nonzero / shifted-out bit
- alu_zero  out  1  alu_result == 0
- alu_neg  out  1  alu_result[WIDTH-1]
- alu_ovf  out  1  signed overflow (add/sub classes only, else 0)
- busy  out  1  multiply in progress

## Operation
- Accept = in_valid & in_ready. Operands and func_sel are latched only on accept.
- FSM states: IDLE, MUL, DONE.
  - IDLE: accept of a non-multiply op -> DONE. Accept of 1101 -> MUL.
  - MUL: runs for WIDTH cycles, then -> DONE.
  - DONE: out_valid=1. out_ready -> IDLE, or directly to DONE/MUL if a new request is accepted in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Never high in MUL.
- Opcodes (all arithmetic mod 2^WIDTH; cout = bit WIDTH of the (WIDTH+1)-bit sum):
  - 0000 A; 0111 A
  - 0001 A+1
  - 0010 A+B; 0011 A+B+1
  - 0100 A+~B (A-B-1); 0101 A+~B+1 (A-B)
  - 0110 A+all-ones (A-1); cout=1 unless A==0
  - 1000 ~A (bitwise); 1001 ~A
  - 1010 A&B; 1011 A^B; 1100 A|B
  - 1101 A*B, low WIDTH bits
  - 1110 logical shift right by 1; cout=A[0]
  - 1111 rotate right by 1; cout=A[0]
- All logic ops are bitwise; cout=0 for passes and logic ops.
- ovf: set when both add inputs (A and B, or A and ~B) have equal sign and the result sign differs; 0 for 0001/0110 unless the A sign flips from 0 to 1 (0001) or from 1 to 0 (0110).
- Multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH-bit accumulator. cout = |product[2*WIDTH-1:WIDTH]. ovf=0.
- zero/neg are always derived from the final alu_result.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, alu_result=0, all flags 0, accumulator 0.
- Single-cycle ops: accept in cycle N -> out_valid, result and flags in N+1.
- Multiply: accept in N -> busy high in N+1..N+WIDTH -> out_valid in N+WIDTH+1.
- Result and flags hold stable while out_valid & !out_ready.
- Back-to-back throughput: one single-cycle op per clock when out_ready is held high.
- in_valid while in_ready=0: ignored; the request is not latched.
- rst asserted mid-multiply or with out_valid high: immediately returns to reset values. The pending result is discarded.
- Undefined opcodes: none; all 16 codes are defined.

## Test plan
- WIDTH=8, 0010, A=0xFF, B=0x01, out_ready=1 -> next cycle result=0x00, cout=1, zero=1, ovf=0.
- 0101, A=0x80, B=0x01 -> result=0x7F, cout=1, ovf=1, neg=0. Then 0110, A=0x00 -> result=0xFF, cout=0, neg=1.
- 1101, A=0x0F, B=0x11 -> busy for 8 cycles; out_valid at accept+9; result=0xFF, cout=0. Then A=0x10, B=0x10 -> result=0x00, cout=1, zero=1.
- Hold out_ready=0 after a 1011 (A=0xAA, B=0xFF -> 0x55): result holds, in_ready=0 and a new in_valid is ignored for 5 cycles; raise out_ready with in_valid high -> same-cycle accept, next result follows one cycle later.
- Stream 1110, 1111, 1010 with A=0x81, B=0x0F, out_ready=1 -> results 0x40 (cout=1), 0xC0 (cout=1), 0x01 on consecutive cycles.
- Assert rst at cycle 3 of a multiply -> out_valid=0, busy=0, result=0, in_ready=1 asynchronously; the next op completes normally.

Source files
------------

// File: rtl/vpl_alu_seq_v.sv
// ============================================================================
// vpl_alu_seq_v
// ----------------------------------------------------------------------------
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle operations complete one clock after accept. Multiply runs
// as a shift-add over WIDTH clocks. While a result waits to be consumed, or
// a multiply is running, upstream is back-pressured through in_ready.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   in_valid    in   operation request
//   in_ready    out  request is accepted this cycle when in_valid is high
//   func_sel    in   4-bit opcode, sampled on accept
//   operand_a   in   operand A, sampled on accept
//   operand_b   in   operand B, sampled on accept
//   out_valid   out  result and flags are valid
//   out_ready   in   downstream consumes the result
//   alu_result  out  registered result
//   alu_cout    out  carry out / product high half nonzero / shifted-out bit
//   alu_zero    out  alu_result == 0
//   alu_neg     out  alu_result MSB
//   alu_ovf     out  signed overflow for the add/subtract class
//   busy        out  multiply in progress
// ============================================================================
module vpl_alu_seq_v #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       func_sel,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_cout,
    output logic             alu_zero,
    output logic             alu_neg,
    output logic             alu_ovf,
    output logic             busy
);

    localparam int         CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_MUL   = 4'b1101;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   cout_q, cout_d;
    logic                   zero_q, zero_d;
    logic                   neg_q, neg_d;
    logic                   ovf_q, ovf_d;

    logic                   accept;
    logic [2*WIDTH-1:0]     partial;
    logic [2*WIDTH-1:0]     acc_step;
    logic [WIDTH+1:0]       eval;

    // ------------------------------------------------------------------
    // Single-cycle operation evaluation. Returns {ovf, cout, result}.
    // Opcodes 0000, 0111 (pass A) and 1101 (handled by the multiplier)
    // fall to the default branch.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [3:0]       func,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] nb;
        logic             c;
        logic             v;
        sum = '0;
        r   = a;
        nb  = ~b;
        c   = 1'b0;
        v   = 1'b0;
        case (func)
            4'b0001: begin
                sum = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                // Only a positive-to-negative sign flip counts as overflow.
                v   = ~a[WIDTH-1] & r[WIDTH-1];
            end
            4'b0010, 4'b0011: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, func[0]};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0100, 4'b0101: begin
                sum = {1'b0, a} + {1'b0, nb} + {{WIDTH{1'b0}}, func[0]};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == nb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0110: begin
                // Adding all-ones decrements; the carry is clear only for A == 0.
                sum = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = a[WIDTH-1] & ~r[WIDTH-1];
            end
            4'b1000, 4'b1001: r = ~a;
            4'b1010:          r = a & b;
            4'b1011:          r = a ^ b;
            4'b1100:          r = a | b;
            4'b1110: begin
                r = {1'b0, a[WIDTH-1:1]};
                c = a[0];
            end
            4'b1111: begin
                r = {a[0], a[WIDTH-1:1]};
                c = a[0];
            end
            default:          r = a;
        endcase
        return {v, c, r};
    endfunction

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL);

    assign alu_result = result_q;
    assign alu_cout   = cout_q;
    assign alu_zero   = zero_q;
    assign alu_neg    = neg_q;
    assign alu_ovf    = ovf_q;

    // One multiplier bit per cycle, LSB first; the multiplicand shifts left.
    assign partial  = mplier_q[0] ? mcand_q : '0;
    assign acc_step = acc_q + partial;

    assign eval = alu_eval(func_sel, operand_a, operand_b);

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_MUL: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                acc_d    = acc_step;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == MUL_LAST) begin
                    result_d = acc_step[WIDTH-1:0];
                    cout_d   = |acc_step[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                    zero_d   = (acc_step[WIDTH-1:0] == '0);
                    neg_d    = acc_step[WIDTH-1];
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // Accept only happens in IDLE or a consumed DONE, so it overrides
        // the DONE -> IDLE transition above.
        if (accept) begin
            if (func_sel == OP_MUL) begin
                mcand_d  = {{WIDTH{1'b0}}, operand_a};
                mplier_d = operand_b;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = S_MUL;
            end else begin
                result_d = eval[WIDTH-1:0];
                cout_d   = eval[WIDTH];
                ovf_d    = eval[WIDTH+1];
                zero_d   = (eval[WIDTH-1:0] == '0);
                neg_d    = eval[WIDTH-1];
                state_d  = S_DONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_vpl_alu_seq_v.sv
// ============================================================================
// tb_vpl_alu_seq_v
// Directed bench for vpl_alu_seq_v at WIDTH=8. Inputs change 1 time unit
// after the rising edge; outputs are sampled at that same point.
// Observation vectors are {out_valid, result, cout, zero, neg, ovf}.
// ============================================================================
module tb_vpl_alu_seq_v;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   func_sel;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         alu_cout;
    logic         alu_zero;
    logic         alu_neg;
    logic         alu_ovf;
    logic         busy;

    int errors;
    int checks;

    logic [W+4:0] obs;
    assign obs = {out_valid, alu_result, alu_cout, alu_zero, alu_neg, alu_ovf};

    vpl_alu_seq_v #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .func_sel   (func_sel),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .alu_ovf    (alu_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid  = 1'b1;
        func_sel  = f;
        operand_a = a;
        operand_b = b;
    endtask

    task automatic test_reset();
        logic [W+7:0] got;
        got = {in_ready, busy, obs};
        checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got,
                     {1'b1, 1'b0, 1'b0, 8'h00, 4'b0000});
        end
    endtask

    task automatic test_addsub();
        out_ready = 1'b1;
        drive(4'b0010, 8'hFF, 8'h01);
        step();
        checks++;
        if (obs !== {1'b1, 8'h00, 4'b1100}) begin
            errors++;
            $display("FAIL add_ff_01: got %h expected %h", obs, {1'b1, 8'h00, 4'b1100});
        end
        drive(4'b0101, 8'h80, 8'h01);
        step();
        checks++;
        if (obs !== {1'b1, 8'h7F, 4'b1001}) begin
            errors++;
            $display("FAIL sub_80_01: got %h expected %h", obs, {1'b1, 8'h7F, 4'b1001});
        end
        drive(4'b0110, 8'h00, 8'h55);
        step();
        checks++;
        if (obs !== {1'b1, 8'hFF, 4'b0010}) begin
            errors++;
            $display("FAIL dec_00: got %h expected %h", obs, {1'b1, 8'hFF, 4'b0010});
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL drain_idle: got %b expected %b", {in_ready, out_valid}, 2'b10);
        end
    endtask

    task automatic test_multiply();
        logic [2:0] ctl;
        logic [2:0] exp_ctl;
        int n;
        out_ready = 1'b1;
        drive(4'b1101, 8'h0F, 8'h11);
        step();
        in_valid = 1'b0;
        // k counts cycles after the accepting edge
        for (int k = 1; k <= 9; k++) begin
            ctl     = {busy, out_valid, in_ready};
            exp_ctl = (k <= 8) ? 3'b100 : 3'b011;
            checks++;
            if (ctl !== exp_ctl) begin
                errors++;
                $display("FAIL mul_timing_k%0d: got busy/ov/ir=%b expected %b", k, ctl, exp_ctl);
            end
            if (k < 9) step();
        end
        checks++;
        if (obs !== {1'b1, 8'hFF, 4'b0010}) begin
            errors++;
            $display("FAIL mul_0f_11: got %h expected %h", obs, {1'b1, 8'hFF, 4'b0010});
        end
        // accepted in the same cycle the previous product is consumed
        drive(4'b1101, 8'h10, 8'h10);
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL mul_latency: got %0d cycles expected %0d", n, 9);
        end
        checks++;
        if (obs !== {1'b1, 8'h00, 4'b1100}) begin
            errors++;
            $display("FAIL mul_10_10: got %h expected %h", obs, {1'b1, 8'h00, 4'b1100});
        end
        step();
    endtask

    task automatic test_hold();
        logic [W+5:0] got;
        out_ready = 1'b0;
        drive(4'b1011, 8'hAA, 8'hFF);
        step();
        // a competing request that must not be taken while stalled
        drive(4'b0010, 8'h01, 8'h01);
        for (int k = 0; k < 5; k++) begin
            got = {in_ready, obs};
            checks++;
            if (got !== {1'b0, 1'b1, 8'h55, 4'b0000}) begin
                errors++;
                $display("FAIL hold_c%0d: got %h expected %h", k, got,
                         {1'b0, 1'b1, 8'h55, 4'b0000});
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release_ready: got %b expected %b", in_ready, 1'b1);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 8'h02, 4'b0000}) begin
            errors++;
            $display("FAIL hold_next: got %h expected %h", obs, {1'b1, 8'h02, 4'b0000});
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0]   fn  [3];
        logic [W+4:0] exp [3];
        fn[0] = 4'b1110;  exp[0] = {1'b1, 8'h40, 4'b1000};
        fn[1] = 4'b1111;  exp[1] = {1'b1, 8'hC0, 4'b1010};
        fn[2] = 4'b1010;  exp[2] = {1'b1, 8'h01, 4'b0000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(fn[i], 8'h81, 8'h0F);
            step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL stream_%0d: got %h expected %h", i, obs, exp[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_mul();
        logic [W+6:0] got;
        out_ready = 1'b1;
        drive(4'b1101, 8'h0F, 8'h11);
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        got = {in_ready, busy, obs};
        checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_mul: got %h expected %h", got,
                     {1'b1, 1'b0, 1'b0, 8'h00, 4'b0000});
        end
        step();
        rst = 1'b0;
        step();
        drive(4'b0010, 8'h03, 8'h04);
        step();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 8'h07, 4'b0000}) begin
            errors++;
            $display("FAIL after_reset_add: got %h expected %h", obs, {1'b1, 8'h07, 4'b0000});
        end
        step();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        func_sel  = 4'b0000;
        operand_a = '0;
        operand_b = '0;
        out_ready = 1'b1;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_addsub();
        test_multiply();
        test_hold();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
